// File: rtl/sprite_plot_arbiter.sv
// Round-robin arbiter sharing one VGA write port between the player and enemy sprite plotters.
// Each grant erases the owner's previous rectangle, then draws the new one, one pixel per clock.
module sprite_plot_arbiter #(
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 32,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       p_req,
  input  logic [7:0] p_x,
  input  logic [6:0] p_y,
  input  logic [2:0] p_colour,
  input  logic       e_req,
  input  logic [7:0] e_x,
  input  logic [6:0] e_y,
  input  logic [2:0] e_colour,
  input  logic [2:0] bg_colour,
  output logic       p_done,
  output logic       e_done,
  output logic       busy,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  localparam int CW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int RW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  state_t         state_q;
  logic           owner_q;    // 0 = player, 1 = enemy
  logic           favourE_q;  // 1 when the enemy wins a tie
  logic [7:0]     x_q;
  logic [6:0]     y_q;
  logic [2:0]     colour_q;
  logic [2:0]     bg_q;
  logic [7:0]     lastX_q [2];
  logic [6:0]     lastY_q [2];
  logic [1:0]     lastValid_q;
  logic [CW-1:0]  col_q;
  logic [RW-1:0]  row_q;

  logic           grantEnemy;
  logic           lastCol;
  logic           lastRow;
  logic           active;
  logic [7:0]     baseX;
  logic [6:0]     baseY;
  logic [8:0]     sumX;
  logic [7:0]     sumY;

  assign grantEnemy = e_req && (!p_req || favourE_q);
  assign lastCol    = (col_q == CW'(SPRITE_W - 1));
  assign lastRow    = (row_q == RW'(SPRITE_H - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      favourE_q   <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      colour_q    <= '0;
      bg_q        <= '0;
      lastX_q[0]  <= '0;
      lastX_q[1]  <= '0;
      lastY_q[0]  <= '0;
      lastY_q[1]  <= '0;
      lastValid_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (p_req || e_req) begin
            owner_q  <= grantEnemy;
            x_q      <= grantEnemy ? e_x : p_x;
            y_q      <= grantEnemy ? e_y : p_y;
            colour_q <= grantEnemy ? e_colour : p_colour;
            bg_q     <= bg_colour;
            col_q    <= '0;
            row_q    <= '0;
            state_q  <= lastValid_q[grantEnemy] ? ERASE : DRAW;
          end
        end
        ERASE, DRAW: begin
          // Column advances every cycle; a full scan always takes W*H cycles, clipped or not.
          if (lastCol) begin
            col_q <= '0;
            if (lastRow) begin
              row_q <= '0;
              if (state_q == ERASE) begin
                state_q <= DRAW;
              end else begin
                state_q              <= DONE;
                lastX_q[owner_q]     <= x_q;
                lastY_q[owner_q]     <= y_q;
                lastValid_q[owner_q] <= 1'b1;
              end
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        DONE: begin
          favourE_q <= ~owner_q;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Address sums carry one extra bit so off-screen pixels never wrap back onto the screen.
  always_comb begin
    active = (state_q == ERASE) || (state_q == DRAW);
    baseX  = (state_q == ERASE) ? lastX_q[owner_q] : x_q;
    baseY  = (state_q == ERASE) ? lastY_q[owner_q] : y_q;
    sumX   = {1'b0, baseX} + 9'(col_q);
    sumY   = {1'b0, baseY} + 8'(row_q);
  end

  assign vga_x      = active ? sumX[7:0] : 8'd0;
  assign vga_y      = active ? sumY[6:0] : 7'd0;
  assign vga_colour = (state_q == ERASE) ? bg_q : ((state_q == DRAW) ? colour_q : 3'd0);
  assign vga_plot   = active && (int'(sumX) < SCREEN_W) && (int'(sumY) < SCREEN_H);
  assign busy       = (state_q != IDLE);
  assign p_done     = (state_q == DONE) && !owner_q;
  assign e_done     = (state_q == DONE) && owner_q;

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Bench for sprite_plot_arbiter: directed scenarios then random traffic, checked cycle by cycle
// against a schedule model that expands each grant into its list of expected output cycles.
module tb_sprite_plot_arbiter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       p_req = 1'b0, e_req = 1'b0;
  logic [7:0] p_x = '0, e_x = '0;
  logic [6:0] p_y = '0, e_y = '0;
  logic [2:0] p_colour = '0, e_colour = '0, bg_colour = '0;
  logic       p_done, e_done, busy, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  sprite_plot_arbiter #(.SPRITE_W(W), .SPRITE_H(H), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_x(p_x), .p_y(p_y), .p_colour(p_colour),
    .e_req(e_req), .e_x(e_x), .e_y(e_y), .e_colour(e_colour),
    .bg_colour(bg_colour),
    .p_done(p_done), .e_done(e_done), .busy(busy),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
  );

  always #5 clock = ~clock;

  // Output vector layout: {busy, p_done, e_done, plot, x[7:0], y[6:0], colour[2:0]}
  logic [21:0] dutVec;
  assign dutVec = {busy, p_done, e_done, vga_plot, vga_x, vga_y, vga_colour};

  typedef struct {
    logic [21:0] vec;
    bit          commit;
    bit          owner;
    logic [7:0]  nx;
    logic [6:0]  ny;
  } entry_t;

  entry_t      sched[$];
  logic [7:0]  lastX [2];
  logic [6:0]  lastY [2];
  bit          valid [2];
  bit          lastGrantE = 1'b1;
  logic [21:0] expVec = '0;
  string       phase = "reset";
  int          errors = 0;
  int          checks = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic pushRect(input logic [7:0] bx, input logic [6:0] by, input logic [2:0] col,
                          input bit isDraw, input bit owner);
    entry_t e;
    int sx, sy;
    bit pl;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        sx = int'(bx) + c;
        sy = int'(by) + r;
        pl = (sx < SW) && (sy < SH);
        e.vec    = {1'b1, 1'b0, 1'b0, pl, 8'(sx), 7'(sy), col};
        e.commit = isDraw && (r == H - 1) && (c == W - 1);
        e.owner  = owner;
        e.nx     = bx;
        e.ny     = by;
        sched.push_back(e);
      end
    end
  endtask

  // Advance the model across one clock edge using the inputs driven now, then compare.
  task automatic applyStimulus();
    entry_t e;
    bit g;
    if (reset) begin
      sched.delete();
      valid[0] = 0; valid[1] = 0;
      lastX[0] = '0; lastX[1] = '0;
      lastY[0] = '0; lastY[1] = '0;
      lastGrantE = 1'b1;
    end else if (sched.size() == 0) begin
      if (p_req || e_req) begin
        g = (p_req && e_req) ? !lastGrantE : e_req;
        lastGrantE = g;
        if (valid[g]) pushRect(lastX[g], lastY[g], bg_colour, 1'b0, g);
        pushRect(g ? e_x : p_x, g ? e_y : p_y, g ? e_colour : p_colour, 1'b1, g);
        e.vec = {1'b1, !g, g, 19'd0};
        e.commit = 1'b0; e.owner = g; e.nx = '0; e.ny = '0;
        sched.push_back(e);
      end
    end else begin
      e = sched.pop_front();
      if (e.commit) begin
        lastX[e.owner] = e.nx;
        lastY[e.owner] = e.ny;
        valid[e.owner] = 1'b1;
      end
    end
    @(posedge clock);
    #1;
    expVec = (sched.size() != 0) ? sched[0].vec : 22'd0;
    checkOutput(phase, 32'(dutVec), 32'(expVec));
  endtask

  // Runs until the chosen side's done pulse, checking its latency and returning the plot count.
  task automatic waitDone(input string tag, input bit enemy, input int expLat, input int dropAfter,
                          input bit holdThrough, output int plots);
    int n = 0;
    bit seen = 0;
    plots = 0;
    phase = tag;
    while (!seen && n < 200) begin
      applyStimulus();
      n++;
      plots += int'(vga_plot);
      if (enemy ? e_done : p_done) seen = 1;
      if (n == dropAfter) begin
        if (enemy) e_req = 1'b0; else p_req = 1'b0;
      end
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
    if (!holdThrough) begin
      if (enemy) e_req = 1'b0; else p_req = 1'b0;
    end
  endtask

  initial begin
    int plots;
    $display("[TB] start");

    reset = 1'b1;
    repeat (3) applyStimulus();
    checkOutput("resetOutputs", 32'(dutVec), 32'd0);

    reset = 1'b0;
    p_req = 1'b1; p_x = 8'd10; p_y = 7'd20; p_colour = 3'd5; bg_colour = 3'd0;
    waitDone("firstDraw", 1'b0, W * H + 1, 0, 1'b0, plots);
    checkOutput("firstDrawPlots", 32'(plots), 32'(W * H));
    applyStimulus();

    p_req = 1'b1; p_x = 8'd12; p_y = 7'd20; p_colour = 3'd5; bg_colour = 3'd0;
    waitDone("secondPlot", 1'b0, 2 * W * H + 1, 0, 1'b0, plots);
    checkOutput("secondPlotPlots", 32'(plots), 32'(2 * W * H));
    applyStimulus();

    phase = "simulReset";
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    p_req = 1'b1; p_x = 8'd40; p_y = 7'd50; p_colour = 3'd1;
    e_req = 1'b1; e_x = 8'd80; e_y = 7'd60; e_colour = 3'd2; bg_colour = 3'd3;
    waitDone("simulP", 1'b0, W * H + 1, 0, 1'b0, plots);
    waitDone("simulE", 1'b1, W * H + 2, 0, 1'b1, plots);
    p_req = 1'b1; p_x = 8'd44;
    waitDone("altP", 1'b0, 2 * W * H + 2, 0, 1'b1, plots);
    e_x = 8'd84;
    waitDone("altE", 1'b1, 2 * W * H + 2, 0, 1'b0, plots);
    p_req = 1'b0;
    applyStimulus();

    phase = "clipReset";
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    e_req = 1'b1; e_x = 8'd158; e_y = 7'd119; e_colour = 3'd6;
    waitDone("clip", 1'b1, W * H + 1, 0, 1'b0, plots);
    checkOutput("clipPlots", 32'(plots), 32'd2);
    applyStimulus();

    phase = "midReset";
    p_req = 1'b1; p_x = 8'd30; p_y = 7'd40; p_colour = 3'd7;
    repeat (4) applyStimulus();
    reset = 1'b1; p_req = 1'b0;
    applyStimulus();
    reset = 1'b0;
    checkOutput("midResetPlot", 32'(vga_plot), 32'd0);
    checkOutput("midResetBusy", 32'(busy), 32'd0);
    p_req = 1'b1;
    waitDone("noErase", 1'b0, W * H + 1, 0, 1'b0, plots);
    applyStimulus();

    p_req = 1'b1; p_x = 8'd50; p_y = 7'd10; p_colour = 3'd4; bg_colour = 3'd2;
    waitDone("dropMid", 1'b0, 2 * W * H + 1, 12, 1'b0, plots);
    applyStimulus();
    p_req = 1'b1; p_x = 8'd60;
    waitDone("holdFirst", 1'b0, 2 * W * H + 1, 0, 1'b1, plots);
    p_x = 8'd70;
    waitDone("holdSecond", 1'b0, 2 * W * H + 2, 0, 1'b0, plots);
    applyStimulus();

    // Random traffic: edge-biased corners, occasional hold-through, early drops and resets.
    phase = "random";
    for (int i = 0; i < 4000; i++) begin
      if (expVec[20]) p_req = ($urandom_range(0, 7) == 0);
      else if (!p_req) p_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 63) == 0) p_req = 1'b0;
      if (expVec[19]) e_req = ($urandom_range(0, 7) == 0);
      else if (!e_req) e_req = ($urandom_range(0, 3) == 0);
      else if ($urandom_range(0, 63) == 0) e_req = 1'b0;
      p_x = 8'($urandom_range(0, 1) ? $urandom_range(140, 255) : $urandom_range(0, 255));
      e_x = 8'($urandom_range(0, 1) ? $urandom_range(140, 255) : $urandom_range(0, 255));
      p_y = 7'($urandom_range(0, 1) ? $urandom_range(100, 127) : $urandom_range(0, 127));
      e_y = 7'($urandom_range(0, 1) ? $urandom_range(100, 127) : $urandom_range(0, 127));
      p_colour  = 3'($urandom_range(0, 7));
      e_colour  = 3'($urandom_range(0, 7));
      bg_colour = 3'($urandom_range(0, 7));
      reset = ($urandom_range(0, 399) == 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sprite_plot_arbiter.md
# sprite_plot_arbiter

Shares the single VGA adapter write port between the player and enemy sprite plotters. On each granted request it erases the requester's previous sprite rectangle with the background colour, then fills the new rectangle, one pixel per clock. It sits between the player and enemy meta controllers, which raise a plot request, and the VGA adapter's x/y/colour/plot inputs. When both sides request, it alternates between them round-robin.

## Interface
- SPRITE_W, 16, sprite rectangle width in pixels (≥1)
- SPRITE_H, 32, sprite rectangle height in pixels (≥1)
- SCREEN_W, 160, visible width; pixels with x ≥ SCREEN_W are suppressed
- SCREEN_H, 120, visible height; pixels with y ≥ SCREEN_H are suppressed
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- p_req  in  1  player plot request, level; held until p_done
- p_x, p_y, p_colour  in  8, 7, 3  player top-left corner and fill colour
- e_req  in  1  enemy plot request, level; held until e_done
- e_x, e_y, e_colour  in  8, 7, 3  enemy top-left corner and fill colour
- bg_colour  in  3  erase colour, sampled at grant
- p_done, e_done  out  1  one-cycle completion pulse to the owning requester
- busy  out  1  high in every state except IDLE
- vga_x, vga_y, vga_colour  out  8, 7, 3  pixel address and colour to the VGA adapter
- vga_plot  out  1  pixel write strobe

## Operation
- FSM states: IDLE, ERASE, DRAW, DONE.
- **IDLE**
  - Samples p_req/e_req. If any is high, latch the owner, x, y, colour and bg_colour.
  - Next state is ERASE if the owner's last-position valid bit is set, otherwise DRAW.
- **Arbitration**
  - If only one request is high, grant it.
  - If both are high, grant the one not granted last.
  - After reset the priority pointer favours the player.
- **ERASE**
  - Scans the owner's stored last rectangle in row-major order, column fastest.
  - vga_colour = latched bg_colour.
- **DRAW**
  - Scans the new rectangle the same way. vga_colour = latched colour.
  - On the last pixel, store the new x/y as the owner's last position and set its valid bit.
- **Scan counters**
  - col runs 0..SPRITE_W-1, row runs 0..SPRITE_H-1.
  - Each counter is sized to its own bound and resets to 0 on every phase entry.
- **Pixel address**
  - vga_x = base_x + col, computed in 9 bits.
  - vga_y = base_y + row, computed in 8 bits.
- **Clipping**
  - vga_plot = 1 only when the 9-bit sum < SCREEN_W and the 8-bit sum < SCREEN_H.
  - Clipped pixels still consume their cycle, so phase duration is fixed.
  - The address never wraps onto the screen.
- **DONE**
  - Pulses the owner's done for exactly one cycle, flips the priority pointer, then returns to IDLE.
- **Request handling**
  - Requests are sampled only in IDLE. Dropping req mid-operation has no effect; the operation completes and done still pulses.
  - A requester must drop req in its done cycle; a req still high in the following IDLE cycle is a new request.
  - Input x/y/colour changes after grant are ignored.
- Outputs are decoded from registered state and counters only; there is no combinational path from any input to any output.

## Timing
- **Reset values**
  - State IDLE; all outputs 0; both valid bits 0; priority pointer to player; last positions 0.
  - Reset mid-operation aborts immediately: no done pulse, and vga_plot is 0 in the cycle after reset is sampled.
- Request sampled in IDLE at cycle N → first pixel (vga_plot, or a clipped slot) at cycle N+1.
- ERASE lasts exactly SPRITE_W·SPRITE_H cycles, as does DRAW.
- DONE occupies the cycle after the last DRAW pixel.
- Total service time from grant to done:
  - first plot of a requester: W·H+1 cycles;
  - every later plot: 2·W·H+1 cycles.
- Earliest next grant is the cycle after DONE.
- busy = 1 from N+1 through the DONE cycle inclusive.

## Test plan
Bench uses SPRITE_W=4, SPRITE_H=2.
- **Reset:** hold reset 3 cycles → all outputs 0, busy 0. Then p_req with x=10, y=20, colour=5 → 8 DRAW pixels (10..13, 20..21) with no erase phase, then p_done in cycle 9 after grant.
- **Second plot:** player plots x=12, y=20, colour=5 with bg_colour=0 → 8 ERASE pixels at the old rectangle in colour 0, then 8 DRAW pixels in colour 5, then p_done 17 cycles after grant.
- **Simultaneous requests:** p_req and e_req raised together right after reset → player served first, enemy granted in the IDLE cycle following p_done. Repeat with both high again → enemy is not starved; grants alternate P, E, P, E.
- **Clipping:** enemy at x=158, y=119 → vga_plot high only for (158,119) and (159,119). The other 6 slots have vga_plot=0, and e_done still arrives 9 cycles after grant.
- **Reset mid-operation:** reset asserted mid-DRAW → no done pulse, vga_plot 0 next cycle. The next request for that requester performs no ERASE, because its valid bit was cleared.
- **Request held too long:** req dropped during DRAW → completion and done unchanged. Req held through done → a second operation starts in the following cycle.
